// File: rtl/instruction_fetch.sv
// Instruction fetch: drives ROM address, assembles 1/2-byte instructions,
// and hands them to execute over a valid/ready handshake.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic       program_clk,
    input  logic       reset,
    input  logic       fetch_enable,
    output logic [7:0] address_bus,
    input  logic [7:0] data_bus,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_operand,
    output logic       instr_len,
    output logic [7:0] instr_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_target
);

    typedef enum logic [1:0] {
        S_OP,
        S_IMM,
        S_HOLD
    } state_t;

    state_t     state;
    logic [7:0] pc;
    logic       two_byte;

    assign address_bus = pc;

    always_comb begin
        two_byte = 1'b0;
        if (data_bus[7]) begin
            case (data_bus[6:2])
                5'b00000, 5'b00001, 5'b00011,
                5'b01010, 5'b01100, 5'b01101: two_byte = 1'b1;
                default:                      two_byte = 1'b0;
            endcase
        end
    end

    always_ff @(posedge program_clk or posedge reset) begin
        if (reset) begin
            state         <= S_OP;
            pc            <= RESET_PC;
            instr_valid   <= 1'b0;
            instr_opcode  <= 8'h70;
            instr_operand <= 8'h00;
            instr_len     <= 1'b0;
            instr_pc      <= 8'h00;
        end else if (redirect) begin
            // A coincident handshake has already consumed the held instruction.
            state       <= S_OP;
            pc          <= redirect_target;
            instr_valid <= 1'b0;
        end else if (state == S_HOLD) begin
            // The handshake completes even while fetch is frozen.
            if (instr_ready) begin
                state       <= S_OP;
                instr_valid <= 1'b0;
            end
        end else if (fetch_enable) begin
            case (state)
                S_OP: begin
                    instr_opcode <= data_bus;
                    instr_pc     <= pc;
                    pc           <= pc + 8'd1;
                    if (two_byte) begin
                        state <= S_IMM;
                    end else begin
                        instr_operand <= 8'h00;
                        instr_len     <= 1'b0;
                        instr_valid   <= 1'b1;
                        state         <= S_HOLD;
                    end
                end
                S_IMM: begin
                    instr_operand <= data_bus;
                    instr_len     <= 1'b1;
                    pc            <= pc + 8'd1;
                    instr_valid   <= 1'b1;
                    state         <= S_HOLD;
                end
                default: state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vectors, corner
// sequences and a random stream checked against an instruction-level model.
module tb_instruction_fetch;

    logic       clk;
    logic       reset;
    logic       fetch_enable;
    logic [7:0] address_bus;
    logic [7:0] data_bus;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic       instr_len;
    logic [7:0] instr_pc;
    logic       redirect;
    logic [7:0] redirect_target;

    logic [7:0] rom [256];

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(8'd0)) dut (
        .program_clk     (clk),
        .reset           (reset),
        .fetch_enable    (fetch_enable),
        .address_bus     (address_bus),
        .data_bus        (data_bus),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_opcode    (instr_opcode),
        .instr_operand   (instr_operand),
        .instr_len       (instr_len),
        .instr_pc        (instr_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    assign data_bus = rom[address_bus];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp_op;
        logic [7:0] exp_opnd;
        logic       exp_len;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Two-byte opcodes as listed in the ISA: LD_IMM LD_MEM CMP BRA BHI BEQ.
    function automatic bit is_two(input logic [7:0] b);
        logic [5:0] op;
        op = b[7:2];
        return op == 6'b100000 || op == 6'b100001 || op == 6'b100011 ||
               op == 6'b101010 || op == 6'b101100 || op == 6'b101101;
    endfunction

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!instr_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic do_redirect(input logic [7:0] t);
        redirect        = 1'b1;
        redirect_target = t;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        int         n;
        logic [7:0] fp;
        logic [7:0] eop;
        logic [7:0] eopnd;
        logic       elen;
        int         xfers;
        logic [7:0] codes [6];

        vecs[0] = '{8'd100, 8'h80, 8'h11, 8'h80, 8'h11, 1'b1};
        vecs[1] = '{8'd102, 8'h06, 8'h22, 8'h06, 8'h00, 1'b0};
        vecs[2] = '{8'd104, 8'hB4, 8'h12, 8'hB4, 8'h12, 1'b1};
        vecs[3] = '{8'd106, 8'h88, 8'h33, 8'h88, 8'h00, 1'b0};
        vecs[4] = '{8'd108, 8'hA8, 8'hC3, 8'hA8, 8'hC3, 1'b1};
        vecs[5] = '{8'd110, 8'hAC, 8'h44, 8'hAC, 8'h00, 1'b0};
        vecs[6] = '{8'd112, 8'h84, 8'h5A, 8'h84, 8'h5A, 1'b1};
        vecs[7] = '{8'd114, 8'h8C, 8'hFE, 8'h8C, 8'hFE, 1'b1};

        for (int i = 0; i < 256; i++) rom[i] = 8'h70;
        rom[0] = 8'h80;
        rom[1] = 8'h00;

        reset           = 1'b1;
        fetch_enable    = 1'b1;
        instr_ready     = 1'b1;
        redirect        = 1'b0;
        redirect_target = 8'h00;
        #12;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_opcode", {24'd0, instr_opcode}, 32'h70);
        chk("rst_operand", {24'd0, instr_operand}, 32'h00);
        chk("rst_len", {31'd0, instr_len}, 32'd0);
        chk("rst_pc", {24'd0, instr_pc}, 32'd0);
        chk("rst_addr", {24'd0, address_bus}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First fetch: two-byte LD_IMM at 0 is valid two edges later.
        wait_valid(6, n);
        chk("first_latency", n, 2);
        chk("first_fields", {instr_opcode, instr_operand, 7'd0, instr_len, instr_pc},
            {8'h80, 8'h00, 7'd0, 1'b1, 8'd0});
        chk("first_addr", {24'd0, address_bus}, 32'd2);
        @(negedge clk);

        // Table-driven single instructions.
        instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rom[vecs[i].pc]        = vecs[i].b0;
            rom[vecs[i].pc + 8'd1] = vecs[i].b1;
            do_redirect(vecs[i].pc);
            wait_valid(6, n);
            chk($sformatf("vec%0d", i),
                {instr_opcode, instr_operand, 7'd0, instr_len, instr_pc},
                {vecs[i].exp_op, vecs[i].exp_opnd, 7'd0, vecs[i].exp_len, vecs[i].pc});
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
        end

        // Mixed stream of one-byte instructions at full throughput.
        rom[12] = 8'h99;
        rom[13] = 8'h06;
        rom[14] = 8'h9D;
        do_redirect(8'd12);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid(6, n);
            chk($sformatf("mix%0d_gap", i), n, 1);
            chk($sformatf("mix%0d_pc", i), {24'd0, instr_pc}, 12 + i);
            chk($sformatf("mix%0d_opnd", i), {23'd0, instr_len, instr_operand}, 32'd0);
            @(negedge clk);
        end

        // Backpressure on CMP r2,#254.
        instr_ready = 1'b0;
        rom[40] = 8'h8E;
        rom[41] = 8'hFE;
        rom[42] = 8'h06;
        do_redirect(8'd40);
        wait_valid(6, n);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i),
                {instr_valid, instr_opcode, instr_operand, instr_len, instr_pc, address_bus},
                {1'b1, 8'h8E, 8'hFE, 1'b1, 8'd40, 8'd42});
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("bp_once", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("bp_next", {instr_valid, instr_pc}, {1'b1, 8'd42});

        // Redirect in S_OP after BHI is accepted.
        rom[10] = 8'hB0;
        rom[11] = 8'd37;
        rom[12] = 8'h99;
        rom[37] = 8'h06;
        do_redirect(8'd10);
        instr_ready = 1'b1;
        wait_valid(6, n);
        chk("bhi_fields", {instr_opcode, instr_operand, instr_pc},
            {8'hB0, 8'd37, 8'd10});
        @(negedge clk);
        chk("bhi_sop_addr", {24'd0, address_bus}, 32'd12);
        do_redirect(8'd37);
        chk("redir_addr", {24'd0, address_bus}, 32'd37);
        wait_valid(6, n);
        chk("redir_latency", n, 1);
        chk("redir_pc", {instr_opcode, instr_pc}, {8'h06, 8'd37});
        @(negedge clk);

        // Redirect coinciding with the handshake.
        instr_ready = 1'b0;
        do_redirect(8'd10);
        wait_valid(6, n);
        chk("coin_hold", {instr_opcode, instr_pc}, {8'hB0, 8'd10});
        instr_ready = 1'b1;
        do_redirect(8'd37);
        chk("coin_consumed", {instr_valid, address_bus}, {1'b0, 8'd37});
        wait_valid(6, n);
        chk("coin_pc", {24'd0, instr_pc}, 32'd37);
        @(negedge clk);

        // Wrap-around two-byte fetch at 255.
        rom[255] = 8'h80;
        rom[0]   = 8'h55;
        instr_ready = 1'b0;
        do_redirect(8'd255);
        wait_valid(6, n);
        chk("wrap_fields", {instr_opcode, instr_operand, 7'd0, instr_len, instr_pc},
            {8'h80, 8'h55, 7'd0, 1'b1, 8'd255});
        chk("wrap_addr", {24'd0, address_bus}, 32'd1);
        instr_ready = 1'b1;
        @(negedge clk);

        // Asynchronous reset while in S_IMM.
        rom[0] = 8'h80;
        rom[1] = 8'h00;
        do_redirect(8'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("areset", {instr_valid, address_bus, instr_opcode}, {1'b0, 8'd0, 8'h70});
        @(negedge clk);
        reset = 1'b0;
        wait_valid(6, n);
        chk("areset_refetch", {instr_opcode, instr_len, instr_pc, address_bus},
            {8'h80, 1'b1, 8'd0, 8'd2});
        @(negedge clk);

        // Random stream against an instruction-level model.
        codes[0] = 8'h80;
        codes[1] = 8'h84;
        codes[2] = 8'h8C;
        codes[3] = 8'hA8;
        codes[4] = 8'hB0;
        codes[5] = 8'hB4;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 0)
                rom[i] = codes[$urandom_range(0, 5)] | 8'($urandom_range(0, 3));
            else
                rom[i] = 8'($urandom);
        end
        instr_ready = 1'b0;
        fp = 8'($urandom);
        do_redirect(fp);
        xfers = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready     = $urandom_range(0, 9) < 7;
            fetch_enable    = $urandom_range(0, 9) < 8;
            redirect        = $urandom_range(0, 19) == 0;
            redirect_target = 8'($urandom);
            if (instr_valid && instr_ready) begin
                elen  = is_two(rom[fp]);
                eop   = rom[fp];
                eopnd = elen ? rom[fp + 8'd1] : 8'h00;
                chk("rand_xfer",
                    {instr_opcode, instr_operand, 7'd0, instr_len, instr_pc},
                    {eop, eopnd, 7'd0, elen, fp});
                fp = fp + (elen ? 8'd2 : 8'd1);
                xfers++;
            end
            if (redirect) fp = redirect_target;
            @(negedge clk);
        end
        redirect     = 1'b0;
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        wait_valid(4, n);
        chk("rand_final_pc", {24'd0, instr_pc}, {24'd0, fp});
        chk("rand_progress", {31'd0, xfers > 300}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
